sketch_framebuffer: RTL and testbench

SKETCH_FRAMEBUFFER -- requirements
Module: sketch_framebuffer

---
 rtl/sketch_framebuffer.sv | 133 +++++++++++++
 tb/tb_sketch_framebuffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sketch_framebuffer.sv
// 1-bpp sketch framebuffer: draw/erase port, 1-clk registered RGB565 read port, vsync-aligned full clear.
// Writes are accepted only when idle. A reset or a clear sweeps one pixel per clk and holds busy high.
module sketch_framebuffer #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter logic [15:0] FG_COLOR       = 16'hFFFF,
  parameter logic [15:0] BG_COLOR       = 16'h0000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [$clog2(DISPLAY_WIDTH):0]    wr_x,
  input  logic [$clog2(DISPLAY_HEIGHT):0]   wr_y,
  input  logic                              wr_set,
  input  logic                              clear_req,
  output logic                              busy,
  input  logic [$clog2(DISPLAY_WIDTH):0]    pixel_x,
  input  logic [$clog2(DISPLAY_HEIGHT):0]   pixel_y,
  input  logic                              vsync,
  output logic [15:0]                       pixel_color
);

  localparam int XW   = $clog2(DISPLAY_WIDTH) + 1;
  localparam int YW   = $clog2(DISPLAY_HEIGHT) + 1;
  localparam int NPIX = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int AW   = $clog2(NPIX);

  localparam logic [XW-1:0] X_LIMIT   = XW'(DISPLAY_WIDTH);
  localparam logic [YW-1:0] Y_LIMIT   = YW'(DISPLAY_HEIGHT);
  localparam logic [AW-1:0] ROW_PITCH = AW'(DISPLAY_WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR_PENDING,
    S_CLEARING
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [15:0]     pixel_color_q, pixel_color_d;

  logic            mem_q [NPIX];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic            mem_wdat;

  logic            wr_in_range;
  logic            rd_in_range;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;

  // Range checks gate everything: an out-of-range coordinate must never alias into the next row.
  assign wr_in_range = (wr_x < X_LIMIT) && (wr_y < Y_LIMIT);
  assign rd_in_range = (pixel_x < X_LIMIT) && (pixel_y < Y_LIMIT);
  assign wr_addr     = AW'(wr_y) * ROW_PITCH + AW'(wr_x);
  assign rd_addr     = AW'(pixel_y) * ROW_PITCH + AW'(pixel_x);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdat  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        clr_cnt_d = '0;
        wr_ready  = ~clear_req;
        if (clear_req) begin
          state_d = S_CLEAR_PENDING;
        end else if (wr_valid && wr_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdat  = wr_set;
        end
      end
      S_CLEAR_PENDING: begin
        clr_cnt_d = '0;
        if (vsync) begin
          state_d = S_CLEARING;
        end
      end
      S_CLEARING: begin
        mem_we = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_CLEARING;
        clr_cnt_d = '0;
      end
    endcase

    // Nothing is accepted or written while reset is held; the sweep starts after release.
    if (rst) begin
      wr_ready = 1'b0;
      busy     = 1'b1;
      mem_we   = 1'b0;
    end
  end

  assign pixel_color_d = (rd_in_range && mem_q[rd_addr]) ? FG_COLOR : BG_COLOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_CLEARING;
      clr_cnt_q     <= '0;
      pixel_color_q <= BG_COLOR;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      pixel_color_q <= pixel_color_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_sketch_framebuffer.sv
// Scoreboard bench for sketch_framebuffer on a reduced 24x32 frame so every sweep fits the cycle budget.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_sketch_framebuffer;

  localparam int W    = 24;
  localparam int H    = 32;
  localparam int NPIX = W * H;
  localparam int XW   = $clog2(W) + 1;
  localparam int YW   = $clog2(H) + 1;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic          wr_set;
  logic          clear_req;
  logic          busy;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          vsync;
  logic [15:0]   pixel_color;

  always #5 clk = ~clk;

  sketch_framebuffer #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .FG_COLOR      (FG),
    .BG_COLOR      (BG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_set     (wr_set),
    .clear_req  (clear_req),
    .busy       (busy),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .vsync      (vsync),
    .pixel_color(pixel_color)
  );

  bit          model [NPIX];
  logic [15:0] exp_q [$];
  int          vec = 0;
  int          err = 0;

  function automatic logic [15:0] exp_color(int x, int y);
    if (x < W && y < H && model[y * W + x]) return FG;
    return BG;
  endfunction

  task automatic push_read(int x, int y, logic [15:0] e);
    pixel_x = XW'(x);
    pixel_y = YW'(y);
    exp_q.push_back(e);
  endtask

  task automatic do_write(int x, int y, bit s, output bit acc);
    wr_x     = XW'(x);
    wr_y     = YW'(y);
    wr_set   = s;
    wr_valid = 1'b1;
    #1;
    acc = wr_ready;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_clear_and_vsync();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    logic [15:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL reset_busy: got %b want 1", busy); end
    vec++; if (wr_ready !== 1'b0) begin err++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    vec++; if (pixel_color !== BG) begin err++; $display("FAIL reset_color: got %h want %h", pixel_color, BG); end
    cnt = 0;
    while (busy === 1'b1 && cnt < NPIX + 50) begin cnt++; @(negedge clk); end
    vec++; if (cnt != NPIX) begin err++; $display("FAIL reset_busy_len: got %0d want %0d", cnt, NPIX); end
    vec++; if (wr_ready !== 1'b1) begin err++; $display("FAIL idle_wr_ready: got %b want 1", wr_ready); end
    foreach (model[i]) model[i] = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        push_read(x, y, exp_color(x, y));
        @(negedge clk);
        e = exp_q.pop_front();
        vec++; if (pixel_color !== e) begin err++; $display("FAIL reset_readall(%0d,%0d): got %h want %h", x, y, pixel_color, e); end
      end
    end
  endtask

  task automatic test_write_read();
    bit acc;
    logic [15:0] e;
    do_write(10, 20, 1'b1, acc);
    vec++; if (acc !== 1'b1) begin err++; $display("FAIL wr_accept: got %b want 1", acc); end
    model[20 * W + 10] = 1'b1;
    push_read(10, 20, exp_color(10, 20));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL wr_readback: got %h want %h", pixel_color, e); end
    push_read(11, 20, exp_color(11, 20));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL wr_neighbour: got %h want %h", pixel_color, e); end
    do_write(10, 20, 1'b0, acc);
    model[20 * W + 10] = 1'b0;
    push_read(10, 20, exp_color(10, 20));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL erase_readback: got %h want %h", pixel_color, e); end
  endtask

  task automatic test_out_of_range();
    bit acc;
    logic [15:0] e;
    do_write(W, 0, 1'b1, acc);
    vec++; if (acc !== 1'b1) begin err++; $display("FAIL oor_x_accept: got %b want 1", acc); end
    push_read(0, 1, exp_color(0, 1));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL oor_x_alias: got %h want %h", pixel_color, e); end
    do_write(0, H, 1'b1, acc);
    vec++; if (acc !== 1'b1) begin err++; $display("FAIL oor_y_accept: got %b want 1", acc); end
    do_write(0, 1, 1'b1, acc);
    model[1 * W + 0] = 1'b1;
    push_read(W, 0, BG);
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL oor_read_x: got %h want %h", pixel_color, e); end
    push_read(0, 1, exp_color(0, 1));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL inrange_read(0,1): got %h want %h", pixel_color, e); end
    push_read((1 << XW) - 1, (1 << YW) - 1, BG);
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL oor_read_max: got %h want %h", pixel_color, e); end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int x, y;
    bit s;
    logic [15:0] e;
    for (int i = 0; i < 24; i++) begin
      x = $urandom_range(W - 1, 0);
      y = $urandom_range(H - 1, 0);
      s = 1'($urandom_range(1, 0));
      do_write(x, y, s, acc);
      vec++; if (acc !== 1'b1) begin err++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, acc); end
      model[y * W + x] = s;
      push_read(x, y, exp_color(x, y));
      @(negedge clk);
      e = exp_q.pop_front();
      vec++; if (pixel_color !== e) begin err++; $display("FAIL b2b_read(%0d,%0d): got %h want %h", x, y, pixel_color, e); end
    end
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        push_read(xx, yy, exp_color(xx, yy));
        @(negedge clk);
        e = exp_q.pop_front();
        vec++; if (pixel_color !== e) begin err++; $display("FAIL b2b_readall(%0d,%0d): got %h want %h", xx, yy, pixel_color, e); end
      end
    end
  endtask

  task automatic test_clear_vs_write();
    bit acc;
    int cnt;
    logic [15:0] e;
    do_write(3, 3, 1'b1, acc);
    model[3 * W + 3] = 1'b1;
    clear_req = 1'b1;
    wr_x      = XW'(3);
    wr_y      = YW'(3);
    wr_set    = 1'b0;
    wr_valid  = 1'b1;
    #1;
    vec++; if (wr_ready !== 1'b0) begin err++; $display("FAIL clr_vs_wr_ready: got %b want 0", wr_ready); end
    @(negedge clk);
    clear_req = 1'b0;
    wr_valid  = 1'b0;
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL clr_pending_busy: got %b want 1", busy); end
    push_read(3, 3, exp_color(3, 3));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL clr_write_lost: got %h want %h", pixel_color, e); end
    for (int i = 0; i < 98; i++) begin
      clear_req = (i == 40);
      @(negedge clk);
    end
    clear_req = 1'b0;
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL clr_wait_busy: got %b want 1", busy); end
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < NPIX + 50) begin cnt++; @(negedge clk); end
    vec++; if (cnt != NPIX) begin err++; $display("FAIL clr_sweep_len: got %0d want %0d", cnt, NPIX); end
    foreach (model[i]) model[i] = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        push_read(x, y, exp_color(x, y));
        @(negedge clk);
        e = exp_q.pop_front();
        vec++; if (pixel_color !== e) begin err++; $display("FAIL clr_readall(%0d,%0d): got %h want %h", x, y, pixel_color, e); end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit acc;
    int cnt;
    logic [15:0] e;
    do_write(W - 1, H - 1, 1'b1, acc);
    model[NPIX - 1] = 1'b1;
    pulse_clear_and_vsync();
    repeat (299) @(negedge clk);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL mid_sweep_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < NPIX + 50) begin cnt++; @(negedge clk); end
    vec++; if (cnt != NPIX) begin err++; $display("FAIL rst_restart_len: got %0d want %0d", cnt, NPIX); end
    foreach (model[i]) model[i] = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        push_read(x, y, exp_color(x, y));
        @(negedge clk);
        e = exp_q.pop_front();
        vec++; if (pixel_color !== e) begin err++; $display("FAIL rst_readall(%0d,%0d): got %h want %h", x, y, pixel_color, e); end
      end
    end
  endtask

  task automatic test_clear_during_clearing();
    bit acc;
    int cnt;
    bit quiet;
    logic [15:0] e;
    do_write(0, 0, 1'b1, acc);
    do_write(W - 1, H - 1, 1'b1, acc);
    pulse_clear_and_vsync();
    cnt = 0;
    for (int k = 0; k < NPIX / 2; k++) begin
      if (busy === 1'b1) cnt++;
      @(negedge clk);
    end
    clear_req = 1'b1;
    push_read(0, 0, BG);
    if (busy === 1'b1) cnt++;
    @(negedge clk);
    clear_req = 1'b0;
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL partial_low: got %h want %h", pixel_color, e); end
    push_read(W - 1, H - 1, FG);
    if (busy === 1'b1) cnt++;
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL partial_high: got %h want %h", pixel_color, e); end
    while (busy === 1'b1 && cnt < NPIX + 50) begin cnt++; @(negedge clk); end
    vec++; if (cnt != NPIX) begin err++; $display("FAIL ignore_clr_len: got %0d want %0d", cnt, NPIX); end
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vsync = (i == 5);
      if (busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    vsync = 1'b0;
    vec++; if (quiet !== 1'b1 || busy !== 1'b0) begin err++; $display("FAIL no_requeue: busy got %b want 0", busy); end
    vec++; if (wr_ready !== 1'b1) begin err++; $display("FAIL post_clear_ready: got %b want 1", wr_ready); end
    foreach (model[i]) model[i] = 1'b0;
    push_read(W - 1, H - 1, exp_color(W - 1, H - 1));
    @(negedge clk);
    e = exp_q.pop_front();
    vec++; if (pixel_color !== e) begin err++; $display("FAIL post_clear_high: got %h want %h", pixel_color, e); end
  endtask

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_set    = 1'b0;
    clear_req = 1'b0;
    pixel_x   = '0;
    pixel_y   = '0;
    vsync     = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_clear_vs_write();
    test_reset_mid_sweep();
    test_clear_during_clearing();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vec);
    $fatal(1, "watchdog");
  end

endmodule
